alarm_beeper: RTL and testbench

//  Downstream consumer of the display driver's sound_alarm level. Turns that level into an

---
 rtl/alarm_beeper.sv | 147 ++++++++++++++
 tb/tb_alarm_beeper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_beeper.sv
// rtl/alarm_beeper.sv - alarm cadence beeper: square-wave tone gated by beep/gap/pause timing from the 256 Hz strobe
// Optional feature macro: ALARM_BEEPER_ESCALATE_EN (post-burst pause halves every round, then disappears).
module alarm_beeper #(
    parameter int TONE_DIV    = 28409,
    parameter int ON_TICKS    = 64,
    parameter int OFF_TICKS   = 64,
    parameter int BEEPS       = 4,
    parameter int PAUSE_TICKS = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_256,
    input  logic       sound_alarm,
    output logic       tone_out,
    output logic       beeping,
    output logic [2:0] beep_idx
);

    // Tick counter must hold the longest interval; divider counts 0..TONE_DIV-1.
    localparam int MAX_GB = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_IV = (MAX_GB > PAUSE_TICKS) ? MAX_GB : PAUSE_TICKS;
    localparam int CW     = $clog2(MAX_IV + 1);
    localparam int DW     = $clog2(TONE_DIV);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(BEEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] tick_q;
    logic [DW-1:0] div_q;
    logic [CW-1:0] pause_last;
    logic          skip_pause;

`ifdef ALARM_BEEPER_ESCALATE_EN
    logic [1:0]    round_q;
    logic [CW-1:0] pause_len;

    // Pause shrinks by half each completed burst; a zero-length pause turns into a plain gap.
    assign pause_len  = CW'(PAUSE_TICKS >> round_q);
    assign pause_last = pause_len - CW'(1);
    assign skip_pause = (pause_len == '0);
`else
    // Fixed-length pause after every burst.
    assign pause_last = CW'(PAUSE_TICKS - 1);
    assign skip_pause = 1'b0;
`endif

    // Cadence FSM with tone divider; all outputs registered. Dropping the alarm wins over any tick.
    always_ff @(posedge clk) begin
        if (!reset || !sound_alarm) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            div_q    <= '0;
            tone_out <= 1'b0;
            beeping  <= 1'b0;
            beep_idx <= 3'd0;
`ifdef ALARM_BEEPER_ESCALATE_EN
            round_q  <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= BEEP;
                    tick_q   <= '0;
                    div_q    <= '0;
                    tone_out <= 1'b0;
                    beeping  <= 1'b1;
                    beep_idx <= 3'd0;
`ifdef ALARM_BEEPER_ESCALATE_EN
                    round_q  <= 2'd0;
`endif
                end
                BEEP: begin
                    if (tick_256 && tick_q == ON_LAST) begin
                        tick_q   <= '0;
                        div_q    <= '0;
                        tone_out <= 1'b0;
                        beeping  <= 1'b0;
                        if (beep_idx == IDX_LAST && !skip_pause) begin
                            state_q <= PAUSE;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        if (tick_256) begin
                            tick_q <= tick_q + CW'(1);
                        end
                        if (div_q == DIV_LAST) begin
                            div_q    <= '0;
                            tone_out <= ~tone_out;
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick_256 && tick_q == OFF_LAST) begin
                        state_q  <= BEEP;
                        tick_q   <= '0;
                        div_q    <= '0;
                        tone_out <= 1'b0;
                        beeping  <= 1'b1;
                        // Wrap only happens when the pause has been skipped.
                        beep_idx <= (beep_idx == IDX_LAST) ? 3'd0 : beep_idx + 3'd1;
                    end else if (tick_256) begin
                        tick_q <= tick_q + CW'(1);
                    end
                end
                PAUSE: begin
                    if (tick_256 && tick_q == pause_last) begin
                        state_q  <= BEEP;
                        tick_q   <= '0;
                        div_q    <= '0;
                        tone_out <= 1'b0;
                        beeping  <= 1'b1;
                        beep_idx <= 3'd0;
`ifdef ALARM_BEEPER_ESCALATE_EN
                        if (round_q != 2'd3) begin
                            round_q <= round_q + 2'd1;
                        end
`endif
                    end else if (tick_256) begin
                        tick_q <= tick_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tick_q   <= '0;
                    div_q    <= '0;
                    tone_out <= 1'b0;
                    beeping  <= 1'b0;
                    beep_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_beeper.sv
// tb/tb_alarm_beeper.sv - self-checking bench for alarm_beeper (vector table plus free-running cadence run)
module tb_alarm_beeper;

    localparam int TONE_DIV    = 4;
    localparam int ON_TICKS    = 2;
    localparam int OFF_TICKS   = 2;
    localparam int BEEPS       = 3;
    localparam int PAUSE_TICKS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_256 = 1'b0;
    logic       sound_alarm = 1'b1;
    logic       tone_out;
    logic       beeping;
    logic [2:0] beep_idx;

    int checks = 0;
    int failures = 0;

    alarm_beeper #(
        .TONE_DIV   (TONE_DIV),
        .ON_TICKS   (ON_TICKS),
        .OFF_TICKS  (OFF_TICKS),
        .BEEPS      (BEEPS),
        .PAUSE_TICKS(PAUSE_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_256   (tick_256),
        .sound_alarm(sound_alarm),
        .tone_out   (tone_out),
        .beeping    (beeping),
        .beep_idx   (beep_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       alarm;
        logic       tick;
        logic       tone;
        logic       beep;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic t,
                       input logic tn, input logic b, input logic [2:0] i);
        vec_t v;
        v.rst_n = r; v.alarm = a; v.tick = t;
        v.tone = tn; v.beep = b; v.idx = i;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    int pause_len[5];
    int seg_b[64];
    int seg_i[64];
    int seg_t[64];
    int seg_n;
    int cur_ticks;
    int tp;
    int tc;
    logic       prev_b;
    logic [2:0] prev_i;
    logic       prev_tone;

    initial begin
        // reset held with alarm high and ticks running
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        // alarm low stays idle
        add(1, 0, 0, 0, 0, 0);
        // raise with coinciding tick: beep0 starts, that tick not counted
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 1, 1, 0);
        add(1, 1, 1, 0, 0, 0);
        // gap, beep1, gap, beep2, pause of 4 ticks
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1);
        add(1, 1, 1, 0, 1, 2);
        add(1, 1, 1, 0, 1, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 1, 1, 0, 1, 0);
        // drop alarm mid-beep on a tick, then re-raise for a full ON interval
        add(1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 1, 1, 0);
        add(1, 1, 1, 0, 0, 0);
        // reset mid-gap, release with alarm high
        add(0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            reset       = vecs[k].rst_n;
            sound_alarm = vecs[k].alarm;
            tick_256    = vecs[k].tick;
            step();
            check($sformatf("vec%0d_tone", k), int'(tone_out), int'(vecs[k].tone));
            check($sformatf("vec%0d_beeping", k), int'(beeping), int'(vecs[k].beep));
            check($sformatf("vec%0d_idx", k), int'(beep_idx), int'(vecs[k].idx));
        end

`ifdef ALARM_BEEPER_ESCALATE_EN
        pause_len = '{4, 2, 1, 2, 2};
`else
        pause_len = '{4, 4, 4, 4, 4};
`endif

        // free-running cadence: tick every 10 clk, record each output segment
        reset = 1'b0; sound_alarm = 1'b0; tick_256 = 1'b0;
        step();
        reset = 1'b1;
        step();
        sound_alarm = 1'b1;
        tp = 3; cur_ticks = 0; seg_n = 0; tc = 0;
        prev_b = 1'b0; prev_i = 3'd0; prev_tone = 1'b0;
        for (int c = 0; c < 3000 && seg_n < 31; c++) begin
            tick_256 = (tp == 9);
            tp = (tp == 9) ? 0 : tp + 1;
            step();
            if (c == 0) check("first_cycle_beeping", int'(beeping), 1);
            if (tick_256) cur_ticks++;
            if (beeping !== prev_b || beep_idx !== prev_i) begin
                seg_b[seg_n] = int'(prev_b);
                seg_i[seg_n] = int'(prev_i);
                seg_t[seg_n] = cur_ticks;
                seg_n++;
                cur_ticks = 0;
                tc = 0;
            end else if (beeping) begin
                tc++;
                if (tone_out !== prev_tone) begin
                    check("tone_half_period", tc, TONE_DIV);
                    tc = 0;
                end
            end
            if (!beeping) check("tone_silent", int'(tone_out), 0);
            prev_b = beeping; prev_i = beep_idx; prev_tone = tone_out;
        end
        tick_256 = 1'b0;
        check("segment_count", seg_n, 31);

        for (int k = 1; k < seg_n && k < 31; k++) begin
            int j, r, p, i;
            j = k - 1; r = j / 6; p = j % 6; i = p / 2;
            check($sformatf("seg%0d_beeping", k), seg_b[k], (p % 2 == 0) ? 1 : 0);
            check($sformatf("seg%0d_idx", k), seg_i[k], i);
            if (p % 2 == 0)
                check($sformatf("seg%0d_ticks", k), seg_t[k], ON_TICKS);
            else if (i < BEEPS - 1)
                check($sformatf("seg%0d_ticks", k), seg_t[k], OFF_TICKS);
            else
                check($sformatf("seg%0d_ticks", k), seg_t[k], pause_len[r]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
